// File: rtl/fib_arbiter_pkg.sv
// Shared encodings and widths for the Fibonacci-unit arbiter.
// The result is 20 bits wide and the index 5 bits wide.
package fib_arbiter_pkg;

    localparam int unsigned FIB_IW = 5;
    localparam int unsigned FIB_RW = 20;
    localparam int unsigned WDOG_W = 8;
    localparam int unsigned ST_W   = 2;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'b00;
    localparam logic [ST_W-1:0] ST_ISSUE = 2'b01;
    localparam logic [ST_W-1:0] ST_WAIT  = 2'b10;
    localparam logic [ST_W-1:0] ST_RESP  = 2'b11;

    typedef logic [FIB_IW-1:0] fib_idx_t;
    typedef logic [FIB_RW-1:0] fib_res_t;

endpackage

// File: rtl/fib_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward
// (mod NREQ) from the slot after last_grant.
module fib_arbiter_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic            any_req,
    output logic [IDW-1:0]  winner
);

    int unsigned    pos;
    logic [IDW-1:0] sel;
    logic           found;

    always_comb begin
        any_req = |req;
        winner  = '0;
        found   = 1'b0;
        pos     = 0;
        sel     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            pos = (32'(last_grant) + k) % NREQ;
            sel = IDW'(pos);
            if (!found && req[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
    end

endmodule

// File: rtl/fib_arbiter.sv
// Round-robin sequencer sharing one Fibonacci FSMD among NREQ requesters,
// with a watchdog that aborts a transaction when the unit never finishes.
module fib_arbiter
    import fib_arbiter_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   clk_amisha,
    input  logic                   reset_n_amisha,
    input  logic [NREQ-1:0]        req_amisha,
    input  logic [NREQ*FIB_IW-1:0] req_i_amisha,
    output logic [NREQ-1:0]        ack_amisha,
    output logic [FIB_RW-1:0]      result_amisha,
    output logic [IDW-1:0]         result_id_amisha,
    output logic                   busy_amisha,
    output logic                   err_tick_amisha,
    output logic                   fib_start_amisha,
    output logic [FIB_IW-1:0]      fib_i_amisha,
    input  logic                   fib_ready_amisha,
    input  logic                   fib_done_tick_amisha,
    input  logic [FIB_RW-1:0]      fib_f_amisha
);

    logic [ST_W-1:0]   state;
    logic [ST_W-1:0]   state_nx;
    logic [IDW-1:0]    cur_id;
    fib_idx_t          cur_i;
    logic [IDW-1:0]    last_grant;
    logic [WDOG_W-1:0] wdog;

    logic              any_req;
    logic [IDW-1:0]    win_id;
    fib_idx_t          win_i;
    logic              timeout_hit;

    fib_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req        (req_amisha),
        .last_grant (last_grant),
        .any_req    (any_req),
        .winner     (win_id)
    );

    // Index of the current winner from the packed index bus
    always_comb begin
        win_i = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (win_id == IDW'(k)) begin
                win_i = req_i_amisha[k*FIB_IW +: FIB_IW];
            end
        end
    end

    assign timeout_hit = (wdog == WDOG_W'(TIMEOUT - 1));

    always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
        if (!reset_n_amisha) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state plus the three state-decoded pulse outputs; done beats timeout
    always_comb begin
        state_nx         = state;
        fib_start_amisha = 1'b0;
        err_tick_amisha  = 1'b0;
        ack_amisha       = '0;
        case (state)
            ST_IDLE: begin
                if (any_req && fib_ready_amisha) begin
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fib_start_amisha = 1'b1;
                state_nx         = ST_WAIT;
            end
            ST_WAIT: begin
                if (fib_done_tick_amisha) begin
                    state_nx = ST_RESP;
                end else if (timeout_hit) begin
                    err_tick_amisha = 1'b1;
                    state_nx        = ST_IDLE;
                end
            end
            ST_RESP: begin
                ack_amisha = NREQ'(1) << cur_id;
                state_nx   = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Transaction latches, watchdog, round-robin pointer and registered outputs
    always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
        if (!reset_n_amisha) begin
            cur_id           <= '0;
            cur_i            <= '0;
            last_grant       <= IDW'(NREQ - 1);
            wdog             <= '0;
            result_amisha    <= '0;
            result_id_amisha <= '0;
            busy_amisha      <= 1'b0;
            fib_i_amisha     <= '0;
        end else begin
            if (state == ST_IDLE && state_nx == ST_ISSUE) begin
                cur_id <= win_id;
                cur_i  <= win_i;
            end
            if (state == ST_ISSUE) begin
                wdog <= '0;
            end else if (state == ST_WAIT) begin
                wdog <= wdog + WDOG_W'(1);
            end
            if (state == ST_WAIT && fib_done_tick_amisha) begin
                result_amisha    <= fib_f_amisha;
                result_id_amisha <= cur_id;
            end
            if (state == ST_RESP || err_tick_amisha) begin
                last_grant <= cur_id;
            end
            busy_amisha <= (state_nx != ST_IDLE);
            if (state_nx == ST_IDLE) begin
                fib_i_amisha <= '0;
            end else if (state == ST_IDLE) begin
                fib_i_amisha <= win_i;
            end else begin
                fib_i_amisha <= cur_i;
            end
        end
    end

endmodule

// File: tb/tb_fib_arbiter.sv
// Self-checking bench for fib_arbiter: behavioural Fibonacci unit, event log,
// and a queue-based round-robin reference model.
module tb_fib_arbiter;
    import fib_arbiter_pkg::*;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned IDW     = 2;
    localparam int unsigned TIMEOUT = 64;

    logic                   clk_amisha;
    logic                   reset_n_amisha;
    logic [NREQ-1:0]        req_amisha;
    logic [NREQ*FIB_IW-1:0] req_i_amisha;
    logic [NREQ-1:0]        ack_amisha;
    logic [FIB_RW-1:0]      result_amisha;
    logic [IDW-1:0]         result_id_amisha;
    logic                   busy_amisha;
    logic                   err_tick_amisha;
    logic                   fib_start_amisha;
    logic [FIB_IW-1:0]      fib_i_amisha;
    logic                   fib_ready_amisha;
    logic                   fib_done_tick_amisha;
    logic [FIB_RW-1:0]      fib_f_amisha;

    fib_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk_amisha           (clk_amisha),
        .reset_n_amisha       (reset_n_amisha),
        .req_amisha           (req_amisha),
        .req_i_amisha         (req_i_amisha),
        .ack_amisha           (ack_amisha),
        .result_amisha        (result_amisha),
        .result_id_amisha     (result_id_amisha),
        .busy_amisha          (busy_amisha),
        .err_tick_amisha      (err_tick_amisha),
        .fib_start_amisha     (fib_start_amisha),
        .fib_i_amisha         (fib_i_amisha),
        .fib_ready_amisha     (fib_ready_amisha),
        .fib_done_tick_amisha (fib_done_tick_amisha),
        .fib_f_amisha         (fib_f_amisha)
    );

    initial clk_amisha = 1'b0;
    always #5 clk_amisha = ~clk_amisha;

    int n_chk  = 0;
    int n_fail = 0;
    int n_seen = 0;
    int cyc    = 0;

    int              lat      = 2;
    bit              lat_rand = 1'b0;
    bit              hang     = 1'b0;
    bit              spur_en  = 1'b0;
    bit              unit_clr = 1'b0;
    logic [NREQ-1:0] drop     = '1;

    function automatic logic [FIB_RW-1:0] fib_ref(input int n);
        logic [FIB_RW-1:0] a, b, t;
        a = '0;
        b = 20'd1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int ref_pick(input logic [NREQ-1:0] rq, input int last);
        for (int k = 1; k <= int'(NREQ); k++) begin
            if (rq[(last + k) % int'(NREQ)]) return (last + k) % int'(NREQ);
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [NREQ*FIB_IW-1:0] ri, input int id);
        logic [FIB_IW-1:0] v;
        v = ri[id*FIB_IW +: FIB_IW];
        return int'(v);
    endfunction

    // Behavioural Fibonacci unit (reset by the system reset)
    logic [FIB_IW-1:0] u_idx;
    int                u_cnt;
    logic              u_busy;
    always @(posedge clk_amisha or negedge reset_n_amisha) begin
        if (!reset_n_amisha) begin
            u_busy <= 1'b0; u_cnt <= 0; u_idx <= '0;
            fib_ready_amisha <= 1'b1; fib_done_tick_amisha <= 1'b0; fib_f_amisha <= '0;
        end else if (unit_clr) begin
            u_busy <= 1'b0; fib_ready_amisha <= 1'b1; fib_done_tick_amisha <= 1'b0;
        end else begin
            fib_done_tick_amisha <= 1'b0;
            if (u_busy) begin
                if (u_cnt == 0) begin
                    if (!hang) begin
                        fib_done_tick_amisha <= 1'b1;
                        fib_f_amisha         <= fib_ref(int'(u_idx));
                        u_busy               <= 1'b0;
                        fib_ready_amisha     <= 1'b1;
                    end
                end else begin
                    u_cnt <= u_cnt - 1;
                end
            end else if (fib_start_amisha) begin
                u_busy           <= 1'b1;
                u_idx            <= fib_i_amisha;
                u_cnt            <= lat_rand ? int'($urandom_range(0, 4)) : lat;
                fib_ready_amisha <= 1'b0;
            end else if (spur_en && $urandom_range(0, 7) == 0) begin
                fib_done_tick_amisha <= 1'b1;
                fib_f_amisha         <= 20'hABCDE;
            end
        end
    end

    // Event log: starts, acks and error ticks with the request bus seen at the deciding edge
    typedef struct {
        int                     kind;
        int                     cyc;
        logic [FIB_IW-1:0]      fi;
        logic [NREQ-1:0]        ack;
        logic [FIB_RW-1:0]      res;
        logic [IDW-1:0]         rid;
        logic                   busy;
        logic [NREQ-1:0]        rq;
        logic [NREQ*FIB_IW-1:0] ri;
    } ev_t;
    ev_t evq[$];

    logic [NREQ-1:0]        snap_req;
    logic [NREQ*FIB_IW-1:0] snap_ri;
    always @(posedge clk_amisha) begin
        cyc      <= cyc + 1;
        snap_req <= req_amisha;
        snap_ri  <= req_i_amisha;
    end

    always @(negedge clk_amisha) begin : mon
        ev_t e;
        if (reset_n_amisha) begin
            e.cyc = cyc; e.fi = fib_i_amisha; e.ack = ack_amisha; e.res = result_amisha;
            e.rid = result_id_amisha; e.busy = busy_amisha; e.rq = snap_req; e.ri = snap_ri;
            e.kind = 0;
            if (fib_start_amisha) evq.push_back(e);
            e.kind = 1;
            if (ack_amisha != '0) evq.push_back(e);
            e.kind = 2;
            if (err_tick_amisha) evq.push_back(e);
        end
    end

    task automatic cycle();
        @(negedge clk_amisha);
        if (ack_amisha != '0 || err_tick_amisha) n_seen++;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (ack_amisha[k] && drop[k]) req_amisha[k] = 1'b0;
        end
    endtask

    task automatic wait_done(input int n, input int budget, output bit ok);
        int s, c;
        s = n_seen;
        c = 0;
        while (n_seen - s < n && c < budget) begin
            cycle();
            c++;
        end
        ok = (n_seen - s >= n);
    endtask

    task automatic set_idx(input int k, input int v);
        req_i_amisha[k*FIB_IW +: FIB_IW] = FIB_IW'(v);
    endtask

    task automatic do_reset();
        @(negedge clk_amisha);
        reset_n_amisha = 1'b0;
        repeat (2) @(negedge clk_amisha);
        evq.delete();
        reset_n_amisha = 1'b1;
    endtask

    task automatic test_reset();
        reset_n_amisha = 1'b0;
        req_amisha     = '0;
        req_i_amisha   = '0;
        repeat (3) @(negedge clk_amisha);
        n_chk++;
        if (ack_amisha !== '0 || err_tick_amisha !== 1'b0 || fib_start_amisha !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses: ack=%b err=%b start=%b want 0", ack_amisha, err_tick_amisha, fib_start_amisha);
        end
        n_chk++;
        if (result_amisha !== '0 || result_id_amisha !== '0) begin
            n_fail++; $display("FAIL reset_result: result=%0d id=%0d want 0", result_amisha, result_id_amisha);
        end
        n_chk++;
        if (busy_amisha !== 1'b0 || fib_i_amisha !== '0) begin
            n_fail++; $display("FAIL reset_busy_fib_i: busy=%b fib_i=%0d want 0", busy_amisha, fib_i_amisha);
        end
        reset_n_amisha = 1'b1;
        repeat (2) cycle();
    endtask

    task automatic test_single();
        bit ok;
        int ns, na;
        ev_t st, ak;
        evq.delete();
        drop = '1; lat = 3;
        set_idx(2, 10);
        req_amisha[2] = 1'b1;
        wait_done(1, 200, ok);
        repeat (10) cycle();
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL single_timeout: no ack within budget"); end
        ns = 0; na = 0;
        foreach (evq[j]) begin
            if (evq[j].kind == 0) begin ns++; st = evq[j]; end
            if (evq[j].kind == 1) begin na++; ak = evq[j]; end
        end
        n_chk++;
        if (ns != 1 || na != 1) begin n_fail++; $display("FAIL single_counts: starts=%0d acks=%0d want 1 1", ns, na); end
        if (ns == 1) begin
            n_chk++;
            if (st.fi !== 5'd10 || st.busy !== 1'b1) begin
                n_fail++; $display("FAIL single_issue: fib_i=%0d busy=%b want 10 1", st.fi, st.busy);
            end
        end
        if (na == 1) begin
            n_chk++;
            if (ak.ack !== 4'b0100 || ak.res !== 20'd55 || ak.rid !== 2'd2) begin
                n_fail++; $display("FAIL single_ack: ack=%b res=%0d id=%0d want 0100 55 2", ak.ack, ak.res, ak.rid);
            end
        end
        n_chk++;
        if (result_amisha !== 20'd55 || busy_amisha !== 1'b0) begin
            n_fail++; $display("FAIL single_hold: result=%0d busy=%b want 55 0", result_amisha, busy_amisha);
        end
    endtask

    task automatic test_all_four();
        bit ok;
        int j;
        logic [FIB_RW-1:0] exp_res[4];
        exp_res = '{20'd0, 20'd1, 20'd46368, 20'd832040};
        @(negedge clk_amisha);
        reset_n_amisha = 1'b0;
        drop = '1; lat = 1;
        set_idx(0, 0); set_idx(1, 1); set_idx(2, 24); set_idx(3, 30);
        req_amisha = '1;
        repeat (2) @(negedge clk_amisha);
        evq.delete();
        reset_n_amisha = 1'b1;
        wait_done(4, 400, ok);
        repeat (6) cycle();
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL four_timeout: acks not seen within budget"); end
        j = 0;
        foreach (evq[e]) begin
            if (evq[e].kind == 1) begin
                if (j < 4) begin
                    n_chk++;
                    if (evq[e].ack !== (NREQ'(1) << j) || evq[e].res !== exp_res[j] || evq[e].rid !== IDW'(j)) begin
                        n_fail++;
                        $display("FAIL four_order_%0d: ack=%b res=%0d id=%0d want %b %0d %0d",
                                 j, evq[e].ack, evq[e].res, evq[e].rid, NREQ'(1) << j, exp_res[j], j);
                    end
                end
                j++;
            end
        end
        n_chk++;
        if (j != 4) begin n_fail++; $display("FAIL four_ack_count: got %0d want 4", j); end
    endtask

    task automatic test_rr();
        bit ok;
        int c, j;
        int exp_id[3];
        exp_id = '{1, 3, 1};
        evq.delete();
        lat = 5; drop = 4'b1000;
        set_idx(1, 7); set_idx(3, 12);
        req_amisha[1] = 1'b1;
        c = 0;
        while (!fib_start_amisha && c < 50) begin cycle(); c++; end
        cycle();
        req_amisha[3] = 1'b1;
        wait_done(3, 300, ok);
        req_amisha[1] = 1'b0;
        drop = '1;
        repeat (12) cycle();
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL rr_timeout: three acks not seen"); end
        j = 0;
        foreach (evq[e]) begin
            if (evq[e].kind == 1) begin
                if (j < 3) begin
                    n_chk++;
                    if (evq[e].rid !== IDW'(exp_id[j]) || evq[e].res !== fib_ref(exp_id[j] == 1 ? 7 : 12)) begin
                        n_fail++; $display("FAIL rr_grant_%0d: id=%0d res=%0d want id %0d", j, evq[e].rid, evq[e].res, exp_id[j]);
                    end
                end
                j++;
            end
        end
        n_chk++;
        if (j != 3) begin n_fail++; $display("FAIL rr_ack_count: got %0d want 3", j); end
    endtask

    task automatic test_idx31();
        bit ok;
        int ne;
        evq.delete();
        drop = '1; lat = 2;
        set_idx(0, 31);
        req_amisha[0] = 1'b1;
        wait_done(1, 200, ok);
        n_chk++;
        if (!ok || ack_amisha !== 4'b0001 || result_amisha !== 20'd297693 || result_id_amisha !== 2'd0) begin
            n_fail++; $display("FAIL idx31: ack=%b result=%0d id=%0d want 0001 297693 0", ack_amisha, result_amisha, result_id_amisha);
        end
        repeat (4) cycle();
        ne = 0;
        foreach (evq[e]) if (evq[e].kind == 2) ne++;
        n_chk++;
        if (ne != 0) begin n_fail++; $display("FAIL idx31_err: err ticks=%0d want 0", ne); end
    endtask

    task automatic test_timeout();
        bit ok;
        int ns, na, ne, c_st, c_er;
        evq.delete();
        hang = 1'b1; lat = 0; drop = '1;
        set_idx(2, 9);
        req_amisha[2] = 1'b1;
        wait_done(1, 200, ok);
        n_chk++;
        if (!ok || err_tick_amisha !== 1'b1 || ack_amisha !== '0) begin
            n_fail++; $display("FAIL timeout_abort: err=%b ack=%b want 1 0", err_tick_amisha, ack_amisha);
        end
        cycle();
        n_chk++;
        if (busy_amisha !== 1'b0 || err_tick_amisha !== 1'b0) begin
            n_fail++; $display("FAIL timeout_idle: busy=%b err=%b want 0 0", busy_amisha, err_tick_amisha);
        end
        ns = 0; na = 0; ne = 0; c_st = 0; c_er = 0;
        foreach (evq[e]) begin
            if (evq[e].kind == 0) begin ns++; c_st = evq[e].cyc; end
            if (evq[e].kind == 1) na++;
            if (evq[e].kind == 2) begin ne++; c_er = evq[e].cyc; end
        end
        n_chk++;
        if (ns != 1 || na != 0 || ne != 1) begin
            n_fail++; $display("FAIL timeout_counts: starts=%0d acks=%0d errs=%0d want 1 0 1", ns, na, ne);
        end
        n_chk++;
        if (c_er - c_st != int'(TIMEOUT)) begin
            n_fail++; $display("FAIL timeout_delay: err %0d cycles after issue want %0d", c_er - c_st, TIMEOUT);
        end
        unit_clr = 1'b1; hang = 1'b0;
        cycle();
        unit_clr = 1'b0;
        wait_done(1, 200, ok);
        n_chk++;
        if (!ok || ack_amisha !== 4'b0100 || result_amisha !== 20'd34) begin
            n_fail++; $display("FAIL timeout_recover: ack=%b result=%0d want 0100 34", ack_amisha, result_amisha);
        end
        repeat (4) cycle();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int c, j, ns;
        logic [FIB_IW-1:0] first_fi;
        evq.delete();
        drop = '1; lat = 5;
        set_idx(0, 3);
        req_amisha[0] = 1'b1;
        wait_done(1, 200, ok);
        repeat (3) cycle();
        set_idx(1, 4);
        req_amisha[1] = 1'b1;
        c = 0;
        while (!fib_start_amisha && c < 50) begin cycle(); c++; end
        cycle();
        set_idx(0, 6);
        req_amisha[0] = 1'b1;
        #2;
        reset_n_amisha = 1'b0;
        #1;
        n_chk++;
        if (busy_amisha !== 1'b0 || fib_i_amisha !== '0 || result_amisha !== '0 || result_id_amisha !== '0 ||
            ack_amisha !== '0 || fib_start_amisha !== 1'b0 || err_tick_amisha !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs: busy=%b fib_i=%0d result=%0d id=%0d ack=%b want all 0",
                               busy_amisha, fib_i_amisha, result_amisha, result_id_amisha, ack_amisha);
        end
        repeat (2) @(negedge clk_amisha);
        evq.delete();
        reset_n_amisha = 1'b1;
        wait_done(2, 300, ok);
        repeat (4) cycle();
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL midreset_timeout: two acks not seen"); end
        j = 0; ns = 0; first_fi = '1;
        foreach (evq[e]) begin
            if (evq[e].kind == 0) begin
                if (ns == 0) first_fi = evq[e].fi;
                ns++;
            end
            if (evq[e].kind == 1) begin
                if (j < 2) begin
                    n_chk++;
                    if (evq[e].rid !== IDW'(j) || evq[e].res !== (j == 0 ? 20'd8 : 20'd3)) begin
                        n_fail++; $display("FAIL midreset_ack_%0d: id=%0d res=%0d want %0d", j, evq[e].rid, evq[e].res, j);
                    end
                end
                j++;
            end
        end
        n_chk++;
        if (first_fi !== 5'd6) begin n_fail++; $display("FAIL midreset_first: fib_i=%0d want 6", first_fi); end
    endtask

    task automatic test_random();
        int ref_last, id, ix, na, ns;
        int pend_id[$];
        int pend_ix[$];
        do_reset();
        drop = '1; lat_rand = 1'b1; spur_en = 1'b1;
        for (int t = 0; t < 800; t++) begin
            cycle();
            for (int k = 0; k < int'(NREQ); k++) begin
                if (!req_amisha[k] && $urandom_range(0, 5) == 0) begin
                    set_idx(k, int'($urandom_range(0, 31)));
                    req_amisha[k] = 1'b1;
                end else if (req_amisha[k] && $urandom_range(0, 39) == 0) begin
                    req_amisha[k] = 1'b0;
                end else if (req_amisha[k] && $urandom_range(0, 19) == 0) begin
                    set_idx(k, int'($urandom_range(0, 31)));
                end
            end
        end
        req_amisha = '0;
        repeat (40) cycle();
        lat_rand = 1'b0; spur_en = 1'b0;
        ref_last = int'(NREQ) - 1;
        na = 0; ns = 0;
        foreach (evq[e]) begin
            if (evq[e].kind == 0) begin
                ns++;
                id = ref_pick(evq[e].rq, ref_last);
                n_chk++;
                if (id < 0 || evq[e].fi !== FIB_IW'(idx_of(evq[e].ri, id))) begin
                    n_fail++; $display("FAIL rand_issue @%0d: fib_i=%0d req=%b want id %0d", evq[e].cyc, evq[e].fi, evq[e].rq, id);
                end
                pend_id.push_back(id);
                pend_ix.push_back(id < 0 ? 0 : idx_of(evq[e].ri, id));
            end else if (evq[e].kind == 1) begin
                na++;
                n_chk++;
                if (pend_id.size() == 0) begin
                    n_fail++; $display("FAIL rand_ack @%0d: ack=%b with no issued transaction", evq[e].cyc, evq[e].ack);
                end else begin
                    id = pend_id.pop_front();
                    ix = pend_ix.pop_front();
                    if (id >= 0) ref_last = id;
                    if (evq[e].ack !== (NREQ'(1) << id) || evq[e].rid !== IDW'(id) || evq[e].res !== fib_ref(ix)) begin
                        n_fail++; $display("FAIL rand_ack @%0d: ack=%b id=%0d res=%0d want id %0d res %0d",
                                           evq[e].cyc, evq[e].ack, evq[e].rid, evq[e].res, id, fib_ref(ix));
                    end
                end
            end else begin
                n_chk++;
                n_fail++; $display("FAIL rand_err @%0d: unexpected err_tick", evq[e].cyc);
            end
        end
        n_chk++;
        if (ns != na || ns < 20) begin n_fail++; $display("FAIL rand_balance: starts=%0d acks=%0d want equal and >=20", ns, na); end
    endtask

    initial begin
        reset_n_amisha = 1'b0;
        req_amisha     = '0;
        req_i_amisha   = '0;
        test_reset();
        test_single();
        test_all_four();
        test_rr();
        test_idx31();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
